// File: rtl/lcd_timing_gen_if.sv
// Pixel-enable and video timing outputs of the LCD timing generator.
// The master drives the timing and the slave consumes it and supplies the enable.
interface lcd_timing_gen_if #(
    parameter int CNT_W = 10
);
    logic             en;
    logic             hsync;
    logic             vsync;
    logic             de;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             line_start;
    logic             frame_start;

    modport master (
        input  en,
        output hsync, vsync, de, x, y, line_start, frame_start
    );

    modport slave (
        output en,
        input  hsync, vsync, de, x, y, line_start, frame_start
    );
endinterface

// File: rtl/lcd_timing_gen.sv
// LCD timing generator: line and frame counters advanced by the pixel enable.
// Every output is registered from the decode of the counters before they advance.
module lcd_timing_gen #(
    parameter int H_SYNC   = 41,
    parameter int H_BP     = 2,
    parameter int H_ACTIVE = 480,
    parameter int H_FP     = 2,
    parameter int V_SYNC   = 10,
    parameter int V_BP     = 2,
    parameter int V_ACTIVE = 272,
    parameter int V_FP     = 2,
    parameter int CNT_W    = 10,
    parameter int SYNC_POL = 0,
    parameter int DE_ONLY  = 0
) (
    input  logic                clk,
    input  logic                nrst,
    lcd_timing_gen_if.master    bus
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    generate
        if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_total
            $error("lcd_timing_gen: H_TOTAL or V_TOTAL does not fit in CNT_W bits");
        end
        if (H_SYNC == 0 || H_ACTIVE == 0 || V_SYNC == 0 || V_ACTIVE == 0) begin : g_bad_zero
            $error("lcd_timing_gen: sync and active widths must be non-zero");
        end
    endgenerate

    localparam logic [CNT_W-1:0] H_SYNC_C = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] H_ACT_S  = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] H_ACT_N  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_SYNC_C = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] V_ACT_S  = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] V_ACT_N  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

    localparam logic SYNC_ON  = 1'(SYNC_POL);
    localparam logic SYNC_OFF = ~SYNC_ON;
    localparam logic SYNC_DIS = (DE_ONLY != 0);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic [CNT_W-1:0] h_off;
    logic [CNT_W-1:0] v_off;
    logic             h_act;
    logic             v_act;
    logic             h_in_sync;
    logic             v_in_sync;

    // Offsets into the active window; an offset below the active width is
    // only trusted when the counter is at or past the window start.
    always_comb begin
        h_off     = h_cnt - H_ACT_S;
        v_off     = v_cnt - V_ACT_S;
        h_act     = (h_cnt >= H_ACT_S) && (h_off < H_ACT_N);
        v_act     = (v_cnt >= V_ACT_S) && (v_off < V_ACT_N);
        h_in_sync = (h_cnt < H_SYNC_C);
        v_in_sync = (v_cnt < V_SYNC_C);
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            h_cnt           <= '0;
            v_cnt           <= '0;
            bus.hsync       <= SYNC_OFF;
            bus.vsync       <= SYNC_OFF;
            bus.de          <= 1'b0;
            bus.x           <= '0;
            bus.y           <= '0;
            bus.line_start  <= 1'b0;
            bus.frame_start <= 1'b0;
        end else if (bus.en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
            bus.hsync       <= (!SYNC_DIS && h_in_sync) ? SYNC_ON : SYNC_OFF;
            bus.vsync       <= (!SYNC_DIS && v_in_sync) ? SYNC_ON : SYNC_OFF;
            bus.de          <= h_act && v_act;
            bus.x           <= (h_act && v_act) ? h_off : '0;
            bus.y           <= (h_act && v_act) ? v_off : '0;
            bus.line_start  <= (h_cnt == '0);
            bus.frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end
    end
endmodule

// File: tb/tb_lcd_timing_gen.sv
// Self-checking bench: two builds (normal timing, and DE-only with high sync polarity)
// compared every edge against a frame-position reference model.
module tb_lcd_timing_gen;
    localparam int HT = 15;
    localparam int VT = 8;
    localparam int FT = HT * VT;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    logic en   = 1'b0;

    always #5 clk = ~clk;

    lcd_timing_gen_if #(.CNT_W(4)) bus_a ();
    lcd_timing_gen_if #(.CNT_W(4)) bus_b ();
    assign bus_a.en = en;
    assign bus_b.en = en;

    lcd_timing_gen #(
        .H_SYNC(2), .H_BP(3), .H_ACTIVE(8), .H_FP(2),
        .V_SYNC(1), .V_BP(2), .V_ACTIVE(4), .V_FP(1),
        .CNT_W(4), .SYNC_POL(0), .DE_ONLY(0)
    ) dut_a (.clk(clk), .nrst(nrst), .bus(bus_a));

    lcd_timing_gen #(
        .H_SYNC(2), .H_BP(3), .H_ACTIVE(8), .H_FP(2),
        .V_SYNC(1), .V_BP(2), .V_ACTIVE(4), .V_FP(1),
        .CNT_W(4), .SYNC_POL(1), .DE_ONLY(1)
    ) dut_b (.clk(clk), .nrst(nrst), .bus(bus_b));

    // {hsync, vsync, de, x, y, line_start, frame_start}
    logic [12:0] obs_a, obs_b, exp_a, exp_b;
    assign obs_a = {bus_a.hsync, bus_a.vsync, bus_a.de, bus_a.x, bus_a.y,
                    bus_a.line_start, bus_a.frame_start};
    assign obs_b = {bus_b.hsync, bus_b.vsync, bus_b.de, bus_b.x, bus_b.y,
                    bus_b.line_start, bus_b.frame_start};

    localparam logic [12:0] RST_A = 13'b1_1_0_0000_0000_0_0;
    localparam logic [12:0] RST_B = 13'b0_0_0_0000_0000_0_0;

    int n_tests = 0;
    int n_fail  = 0;
    int pos     = 0;   // position in the frame the DUT counters hold, 0..FT-1

    function automatic logic [12:0] model_out(input int p, input bit de_only);
        int h = p % HT;
        int v = p / HT;
        logic hs, vs, de;
        logic [3:0] xx, yy;
        de = (h >= 5) && (h < 13) && (v >= 3) && (v < 7);
        xx = de ? 4'(h - 5) : 4'd0;
        yy = de ? 4'(v - 3) : 4'd0;
        hs = de_only ? 1'b0 : (h >= 2);
        vs = de_only ? 1'b0 : (v >= 1);
        return {hs, vs, de, xx, yy, (h == 0), (p == 0)};
    endfunction

    // Drive one edge and advance the model; returns 1 ns after the edge.
    task automatic step(input logic en_v, input logic nrst_v);
        nrst = nrst_v;
        en   = en_v;
        @(posedge clk);
        if (!nrst_v) begin
            pos   = 0;
            exp_a = RST_A;
            exp_b = RST_B;
        end else if (en_v) begin
            exp_a = model_out(pos, 1'b0);
            exp_b = model_out(pos, 1'b1);
            pos   = (pos + 1) % FT;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'($urandom_range(0, 1)), 1'b0);
            n_tests++;
            if (obs_a !== RST_A) begin
                n_fail++;
                $display("FAIL reset_a: got %b want %b", obs_a, RST_A);
            end
            n_tests++;
            if (obs_b !== RST_B) begin
                n_fail++;
                $display("FAIL reset_b: got %b want %b", obs_b, RST_B);
            end
        end
    endtask

    task automatic test_first_output();
        step(1'b1, 1'b1);
        n_tests++;
        if (obs_a[12] !== 1'b0 || obs_a[11] !== 1'b0 || obs_a[0] !== 1'b1 || obs_a[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL first_output: got hs=%b vs=%b ls=%b fs=%b want 0 0 1 1",
                     obs_a[12], obs_a[11], obs_a[1], obs_a[0]);
        end
        n_tests++;
        if (obs_b !== exp_b) begin
            n_fail++;
            $display("FAIL first_output_b: got %b want %b", obs_b, exp_b);
        end
    endtask

    task automatic test_full_frame();
        int last_fs = 0;
        int n_fs = 0, n_de = 0, n_vs = 0, n_hs = 0;
        for (int i = 1; i <= 2 * FT; i++) begin
            step(1'b1, 1'b1);
            n_tests++;
            if (obs_a !== exp_a) begin
                n_fail++;
                $display("FAIL frame_a cyc %0d: got %b want %b", i, obs_a, exp_a);
            end
            n_tests++;
            if (obs_b !== exp_b) begin
                n_fail++;
                $display("FAIL frame_b cyc %0d: got %b want %b", i, obs_b, exp_b);
            end
            if (i <= FT) begin
                n_de += int'(obs_a[10]);
                n_vs += int'(!obs_a[11]);
                n_hs += int'(!obs_a[12]);
            end
            if (obs_a[0]) begin
                n_fs++;
                n_tests++;
                if (i - last_fs != FT) begin
                    n_fail++;
                    $display("FAIL frame_period: got %0d want %0d", i - last_fs, FT);
                end
                last_fs = i;
            end
        end
        n_tests++;
        if (n_de != 32) begin
            n_fail++;
            $display("FAIL de_count: got %0d want 32", n_de);
        end
        n_tests++;
        if (n_vs != 15) begin
            n_fail++;
            $display("FAIL vsync_low: got %0d want 15", n_vs);
        end
        n_tests++;
        if (n_hs != 16) begin
            n_fail++;
            $display("FAIL hsync_low: got %0d want 16", n_hs);
        end
        n_tests++;
        if (n_fs != 2) begin
            n_fail++;
            $display("FAIL frame_pulses: got %0d want 2", n_fs);
        end
    endtask

    task automatic test_random_en();
        step(1'b1, 1'b0);
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 2) != 0), 1'b1);
            n_tests++;
            if (obs_a !== exp_a) begin
                n_fail++;
                $display("FAIL rand_en_a cyc %0d: got %b want %b", i, obs_a, exp_a);
            end
            n_tests++;
            if (obs_b !== exp_b) begin
                n_fail++;
                $display("FAIL rand_en_b cyc %0d: got %b want %b", i, obs_b, exp_b);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        // bring the counters to h=9, v=4
        for (int i = 0; i < 2 * FT && pos != 4 * HT + 9; i++)
            step(1'b1, 1'b1);
        n_tests++;
        if (pos != 4 * HT + 9) begin
            n_fail++;
            $display("FAIL reach_h9v4: got pos %0d want %0d", pos, 4 * HT + 9);
        end
        step(1'($urandom_range(0, 1)), 1'b0);
        n_tests++;
        if (obs_a !== RST_A || obs_b !== RST_B) begin
            n_fail++;
            $display("FAIL mid_reset: got %b/%b want %b/%b", obs_a, obs_b, RST_A, RST_B);
        end
        step(1'b0, 1'b1);
        n_tests++;
        if (obs_a !== RST_A) begin
            n_fail++;
            $display("FAIL mid_reset_hold: got %b want %b", obs_a, RST_A);
        end
        step(1'b1, 1'b1);
        n_tests++;
        if (obs_a[0] !== 1'b1 || obs_a[9:6] !== 4'd0 || obs_a[5:2] !== 4'd0 || obs_a[12] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_restart: got fs=%b x=%0d y=%0d hs=%b want 1 0 0 0",
                     obs_a[0], obs_a[9:6], obs_a[5:2], obs_a[12]);
        end
    endtask

    task automatic test_nrst_glitch();
        for (int i = 0; i < 20 + int'($urandom_range(0, 30)); i++)
            step(1'b1, 1'b1);
        nrst = 1'b0;
        #2;
        nrst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1);
            n_tests++;
            if (obs_a !== exp_a || obs_b !== exp_b) begin
                n_fail++;
                $display("FAIL nrst_glitch cyc %0d: got %b/%b want %b/%b",
                         i, obs_a, obs_b, exp_a, exp_b);
            end
        end
    endtask

    initial begin
        exp_a = RST_A;
        exp_b = RST_B;
        #1;
        test_reset();
        test_first_output();
        test_full_frame();
        test_random_en();
        test_reset_mid_frame();
        test_nrst_glitch();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/lcd_timing_gen.md
LCD_TIMING_GEN -- requirements
Module: lcd_timing_gen

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset; all state SHALL update on the rising edge of clk only.
REQ-002 Parameters SHALL be as follows (name, default, meaning):
- H_SYNC, 41, hsync width in pixels
- H_BP, 2, horizontal back porch
- H_ACTIVE, 480, visible pixels per line
- H_FP, 2, horizontal front porch
- V_SYNC, 10, vsync width in lines
- V_BP, 2, vertical back porch
- V_ACTIVE, 272, visible lines per frame
- V_FP, 2, vertical front porch
- CNT_W, 10, counter and coordinate width
- SYNC_POL, 0, active level of hsync/vsync
- DE_ONLY, 0, when 1, hsync/vsync are held at their inactive level
REQ-003 Ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1, pixel-domain clock
- nrst, in, 1, synchronous active-low reset
- en, in, 1, pixel advance enable
- hsync, out, 1, horizontal sync
- vsync, out, 1, vertical sync
- de, out, 1, data enable
- x, out, CNT_W, active pixel column
- y, out, CNT_W, active line row
- line_start, out, 1, first pixel of every line
- frame_start, out, 1, first pixel of every frame

Function
REQ-004 H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP and V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP; elaboration SHALL fail if either exceeds 2^CNT_W or if any sync/active parameter is 0.
REQ-005 Internal counter h_cnt SHALL advance by 1 on each clk edge with en=1 and wrap from H_TOTAL-1 to 0.
REQ-006 Internal counter v_cnt SHALL advance by 1 only on the edge where h_cnt wraps, and SHALL wrap from V_TOTAL-1 to 0 on that same edge.
REQ-007 With en=0, both counters and all outputs SHALL hold their values.
REQ-008 All outputs SHALL be registered; on an en=1 edge, the outputs SHALL load the decode of the pre-advance (h_cnt, v_cnt), giving a latency of one enabled cycle from counter state to outputs.
REQ-009 Horizontal regions SHALL be:
- sync: h in [0, H_SYNC-1]
- back porch: h in [H_SYNC, H_SYNC+H_BP-1]
- active: h in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1]
- front porch: the remainder
Vertical regions SHALL follow the same pattern using the V_* parameters.
REQ-010 hsync SHALL equal SYNC_POL while h is in the sync region and ~SYNC_POL otherwise; vsync SHALL behave the same way for v. When DE_ONLY=1, both SHALL be held constantly at ~SYNC_POL.
REQ-011 de SHALL be 1 only when h and v are both in their active regions.
REQ-012 When de=1, x SHALL equal h-(H_SYNC+H_BP) and y SHALL equal v-(V_SYNC+V_BP); when de=0, x and y SHALL be 0.
REQ-013 line_start SHALL be 1 for exactly one enabled cycle when the decoded h=0; frame_start SHALL be 1 for exactly one enabled cycle when the decoded h=0 and v=0. Both are level outputs that hold through en=0 gaps.
REQ-014 Subtraction and compare arithmetic SHALL be CNT_W bits wide and unsigned; no output SHALL take a value outside its defined range at any wrap point.

Reset
REQ-015 When nrst=0 on a clk edge, the following SHALL apply regardless of en and on that same edge:
- h_cnt=0, v_cnt=0
- hsync=vsync=~SYNC_POL, de=0, x=0, y=0, line_start=0, frame_start=0
REQ-016 Reset asserted mid-line or mid-frame SHALL abandon the current frame. The first en=1 edge after release SHALL produce the decode of (0,0): sync active, line_start=1, frame_start=1.
REQ-017 The nrst signal SHALL NOT act asynchronously; a low pulse that does not span a rising clk edge SHALL have no effect.

Verification
Bench parameters: H 2/3/8/2 (H_TOTAL=15), V 1/2/4/1 (V_TOTAL=8), CNT_W=4, SYNC_POL=0.
REQ-018 Release reset, then hold en=1 -> the first output cycle shows hsync=0, vsync=0, frame_start=1; hsync=0 for 2 cycles in every 15; de=1 for 8 consecutive cycles with x=0..7, starting 5 cycles after line_start.
REQ-019 Run a full frame with en=1 -> exactly 120 cycles between frame_start pulses; vsync low for 15 cycles; 32 de cycles in total, with y=0..3 on lines 3..6.
REQ-020 Toggle en pseudo-randomly -> the output sequence, sampled on en=1 edges only, matches REQ-018/019 exactly, and outputs hold on en=0 edges.
REQ-021 Assert nrst=0 for one edge at h=9, v=4 -> the next edge shows reset values; after release, the first enabled output has frame_start=1 and x=y=0.
REQ-022 Rebuild with DE_ONLY=1 and SYNC_POL=1 -> hsync and vsync stay constantly 0; de, x, y and the start pulses are identical to REQ-019.
REQ-023 Rebuild with H_TOTAL=17 and CNT_W=4 -> elaboration fails.
